// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector, MSB-first (clock, reset, x, en, overlap, load, pattern -> q match pulse, count saturating)
module seq_detector_param #(
  parameter int W = 4,
  parameter int CNT_W = 8,
  parameter logic [W-1:0] PAT_INIT = W'(4'b1011)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             load,
  input  logic [W-1:0]     pattern,
  output logic             q,
  output logic [CNT_W-1:0] count
);
  localparam int FW = $clog2(W + 1);
  logic [W-1:0] pat_q, pat_d, hist_q, hist_d, shifted;
  logic [FW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic q_q, q_d, hit, clr;
  always_comb begin
    shifted = {hist_q[W-2:0], x};
    hit = en && !load && fill_q >= FW'(W - 1) && shifted == pat_q;
    clr = load || (hit && !overlap);
    pat_d = load ? pattern : pat_q;
    hist_d = clr ? '0 : en ? shifted : hist_q;
    fill_d = clr ? '0 : en && fill_q != FW'(W) ? fill_q + 1'b1 : fill_q;
    q_d = hit;
    count_d = hit && count_q != '1 ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
      count_q <= '0;
      q_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      count_q <= count_d;
      q_q <= q_d;
    end
  end
  assign q = q_q;
  assign count = count_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param
module tb_seq_detector_param;
  logic clock = 1'b0;
  logic reset, x, en, overlap, load;
  logic [3:0] pattern;
  logic q, q2;
  logic [7:0] count;
  logic [1:0] count2;
  int n_cmp = 0;
  int n_err = 0;

  seq_detector_param u_dut (
    .clock(clock), .reset(reset), .x(x), .en(en), .overlap(overlap),
    .load(load), .pattern(pattern), .q(q), .count(count)
  );

  seq_detector_param #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .x(x), .en(en), .overlap(overlap),
    .load(load), .pattern(pattern), .q(q2), .count(count2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic xv, input logic ev, input logic eq);
    x = xv;
    en = ev;
    @(posedge clock);
    #1;
    chk(tag, {31'd0, q}, {31'd0, eq});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] p);
    load = 1'b1;
    pattern = p;
    x = 1'b1;
    en = 1'b1;
    @(posedge clock);
    #1;
    chk("load_q", {31'd0, q}, 32'd0);
    load = 1'b0;
  endtask

  initial begin
    logic [6:0] s;
    logic [6:0] e;
    logic [1:0] sc [8];
    sc = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset = 1'b1; load = 1'b1; en = 1'b1; overlap = 1'b1; pattern = 4'b0000; x = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = ~x;
      @(posedge clock);
      #1;
      chk($sformatf("reset_q%0d", i), {31'd0, q}, 32'd0);
      chk($sformatf("reset_cnt%0d", i), {24'd0, count}, 32'd0);
      chk($sformatf("reset_cnt_sat%0d", i), {30'd0, count2}, 32'd0);
    end
    reset = 1'b0; load = 1'b0;
    s = 7'b1011011;
    e = 7'b0001001;
    for (int i = 0; i < 7; i++) step($sformatf("ovl_bit%0d", i + 1), s[6-i], 1'b1, e[6-i]);
    chk("ovl_count", {24'd0, count}, 32'd2);
    do_reset();
    chk("rst_count", {24'd0, count}, 32'd0);
    overlap = 1'b0;
    e = 7'b0001000;
    for (int i = 0; i < 7; i++) step($sformatf("novl_bit%0d", i + 1), s[6-i], 1'b1, e[6-i]);
    chk("novl_count", {24'd0, count}, 32'd1);
    do_load(4'b0000);
    chk("load_count_kept", {24'd0, count}, 32'd1);
    overlap = 1'b1;
    e = 7'b0000111;
    for (int i = 0; i < 6; i++) step($sformatf("zero_bit%0d", i + 1), 1'b0, 1'b1, e[5-i]);
    chk("zero_count", {24'd0, count}, 32'd4);
    do_load(4'b1011);
    step("gap_b1", 1'b1, 1'b1, 1'b0);
    step("gap_b2", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("gap_idle%0d", i), 1'b1, 1'b0, 1'b0);
    step("gap_b3", 1'b1, 1'b1, 1'b0);
    step("gap_b4", 1'b1, 1'b1, 1'b1);
    step("gap_after", 1'b1, 1'b0, 1'b0);
    chk("gap_count", {24'd0, count}, 32'd5);
    do_reset();
    do_load(4'b1111);
    overlap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step($sformatf("sat_q_bit%0d", i + 1), 1'b1, 1'b1, i >= 3);
      chk($sformatf("sat_q2_bit%0d", i + 1), {31'd0, q2}, {31'd0, i >= 3});
      chk($sformatf("sat_cnt_bit%0d", i + 1), {30'd0, count2}, {30'd0, sc[i]});
    end
    chk("wide_count", {24'd0, count}, 32'd5);
    do_reset();
    do_load(4'b1111);
    for (int i = 0; i < 3; i++) step($sformatf("pre_rst_bit%0d", i + 1), 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    step("rst_match_q", 1'b1, 1'b1, 1'b0);
    chk("rst_match_cnt", {24'd0, count}, 32'd0);
    chk("rst_match_cnt_sat", {30'd0, count2}, 32'd0);
    reset = 1'b0;
    step("post_rst_bit1", 1'b1, 1'b1, 1'b0);
    step("post_rst_bit2", 1'b0, 1'b1, 1'b0);
    step("post_rst_bit3", 1'b1, 1'b1, 1'b0);
    step("post_rst_bit4", 1'b1, 1'b1, 1'b1);
    chk("post_rst_count", {24'd0, count}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
